// File: rtl/arbiter_nx1_if.sv
// Bus bundle between N masters, the arbiter and one downstream slave.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface arbiter_nx1_if #(
  parameter int N_MASTERS = 4,
  parameter int XLEN      = 32
);
  localparam int ID_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  logic [N_MASTERS-1:0]      i_m_bus_en;
  logic [N_MASTERS-1:0]      i_m_wr_en;
  logic [N_MASTERS*XLEN-1:0] i_m_wr_data;
  logic [N_MASTERS*XLEN-1:0] i_m_addr;
  logic [N_MASTERS*4-1:0]    i_m_byte_en;
  logic [N_MASTERS-1:0]      i_m_atomic;
  logic [N_MASTERS*7-1:0]    i_m_operation;
  logic [N_MASTERS-1:0]      i_m_lock;
  logic [N_MASTERS-1:0]      o_m_ack;
  logic [XLEN-1:0]           o_m_rd_data;

  logic                      i_ack;
  logic [XLEN-1:0]           i_rd_data;
  logic                      o_bus_en;
  logic                      o_wr_en;
  logic [XLEN-1:0]           o_wr_data;
  logic [XLEN-1:0]           o_addr;
  logic [3:0]                o_byte_en;
  logic                      o_atomic;
  logic [6:0]                o_operation;
  logic [ID_W-1:0]           o_id;

  modport slave (
    input  i_m_bus_en, i_m_wr_en, i_m_wr_data, i_m_addr, i_m_byte_en,
           i_m_atomic, i_m_operation, i_m_lock, i_ack, i_rd_data,
    output o_m_ack, o_m_rd_data, o_bus_en, o_wr_en, o_wr_data, o_addr,
           o_byte_en, o_atomic, o_operation, o_id
  );

  modport master (
    output i_m_bus_en, i_m_wr_en, i_m_wr_data, i_m_addr, i_m_byte_en,
           i_m_atomic, i_m_operation, i_m_lock, i_ack, i_rd_data,
    input  o_m_ack, o_m_rd_data, o_bus_en, o_wr_en, o_wr_data, o_addr,
           o_byte_en, o_atomic, o_operation, o_id
  );
endinterface

// File: rtl/arbiter_nx1.sv
// N-to-1 bus arbiter: round-robin or fixed priority, with bounded grant locking.
// One transaction in flight; the granted master's fields are muxed from the registered grant.
module arbiter_nx1 #(
  parameter int N_MASTERS = 4,
  parameter int XLEN      = 32,
  parameter int RR_MODE   = 1,
  parameter int LOCK_MAX  = 8
) (
  input logic           i_clk,
  input logic           i_rst,
  arbiter_nx1_if.slave  bus
);
  localparam int ID_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int LCW  = $clog2(LOCK_MAX) + 1;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] g_q, g_d;
  logic [ID_W-1:0] last_q, last_d;
  logic [LCW-1:0]  lock_cnt_q, lock_cnt_d;
  logic            busy;

  logic [XLEN-1:0] wd_a [N_MASTERS];
  logic [XLEN-1:0] ad_a [N_MASTERS];
  logic [3:0]      be_a [N_MASTERS];
  logic [6:0]      op_a [N_MASTERS];

  for (genvar k = 0; k < N_MASTERS; k++) begin : g_unpack
    assign wd_a[k] = bus.i_m_wr_data[k*XLEN +: XLEN];
    assign ad_a[k] = bus.i_m_addr[k*XLEN +: XLEN];
    assign be_a[k] = bus.i_m_byte_en[k*4 +: 4];
    assign op_a[k] = bus.i_m_operation[k*7 +: 7];
  end

  // Round-robin starts the scan just after the last completed grant.
  function automatic logic [ID_W-1:0] arb_pick(input logic [N_MASTERS-1:0] req,
                                               input logic [ID_W-1:0]      last);
    logic [ID_W-1:0] sel;
    logic            hit;
    int unsigned     idx;
    sel = '0;
    hit = 1'b0;
    for (int unsigned off = 0; off < N_MASTERS; off++) begin
      idx = (RR_MODE != 0) ? ((32'(last) + 32'd1 + off) % N_MASTERS) : off;
      if (!hit && req[idx[ID_W-1:0]]) begin
        hit = 1'b1;
        sel = idx[ID_W-1:0];
      end
    end
    return sel;
  endfunction

  always_comb begin
    state_d    = state_q;
    g_d        = g_q;
    last_d     = last_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (|bus.i_m_bus_en) begin
          state_d = S_BUSY;
          g_d     = arb_pick(bus.i_m_bus_en, last_q);
        end
      end
      S_BUSY: begin
        if (bus.i_ack) begin
          if (bus.i_m_lock[g_q] && bus.i_m_bus_en[g_q] &&
              (lock_cnt_q < LCW'(LOCK_MAX - 1))) begin
            lock_cnt_d = lock_cnt_q + LCW'(1);
          end else begin
            state_d    = S_IDLE;
            lock_cnt_d = '0;
            last_d     = g_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= S_IDLE;
      g_q        <= '0;
      last_q     <= ID_W'(N_MASTERS - 1);
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      g_q        <= g_d;
      last_q     <= last_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  assign busy = (state_q == S_BUSY);

  always_comb begin
    bus.o_m_ack = '0;
    if (busy && bus.i_ack) begin
      bus.o_m_ack[g_q] = 1'b1;
    end
  end

  // o_id tracks g_q directly, so it holds the last grant while idle.
  assign bus.o_id        = g_q;
  assign bus.o_m_rd_data = bus.i_rd_data;
  assign bus.o_bus_en    = busy;
  assign bus.o_wr_en     = busy & bus.i_m_wr_en[g_q];
  assign bus.o_atomic    = busy & bus.i_m_atomic[g_q];
  assign bus.o_wr_data   = busy ? wd_a[g_q] : '0;
  assign bus.o_addr      = busy ? ad_a[g_q] : '0;
  assign bus.o_byte_en   = busy ? be_a[g_q] : '0;
  assign bus.o_operation = busy ? op_a[g_q] : '0;
endmodule

// File: doc/arbiter_nx1.md
ARBITER_NX1 -- requirements
Module: arbiter_nx1

Interface
REQ-001 SHALL provide parameter N_MASTERS, default 4, number of bus masters (2..16).
REQ-002 SHALL provide parameter XLEN, default 32, data/address width.
REQ-003 SHALL provide parameter RR_MODE, default 1; 1 = round-robin, 0 = fixed priority with lowest index winning.
REQ-004 SHALL provide parameter LOCK_MAX, default 8, maximum consecutive locked grants to one master.
REQ-005 SHALL derive localparam ID_W = max(1, clog2(N_MASTERS)).
REQ-006 i_clk  in  1  sole clock, rising edge.
REQ-007 i_rst  in  1  reset, asynchronous and active-low.
REQ-008 i_m_bus_en  in  N_MASTERS  per-master request; held high until that master's ack.
REQ-009 i_m_wr_en  in  N_MASTERS  per-master write enable.
REQ-010 i_m_wr_data  in  N_MASTERS*XLEN  per-master write data, master k at bits [k*XLEN +: XLEN].
REQ-011 i_m_addr  in  N_MASTERS*XLEN  per-master address, same packing as i_m_wr_data.
REQ-012 i_m_byte_en  in  N_MASTERS*4  per-master byte enables.
REQ-013 i_m_atomic  in  N_MASTERS  per-master atomic flag.
REQ-014 i_m_operation  in  N_MASTERS*7  per-master atomic opcode.
REQ-015 i_m_lock  in  N_MASTERS  per-master request to retain the grant after the current ack.
REQ-016 o_m_ack  out  N_MASTERS  per-master ack; one-hot or zero.
REQ-017 o_m_rd_data  out  XLEN  read data broadcast to all masters.
REQ-018 i_ack, i_rd_data  in  1, XLEN  downstream ack and read data.
REQ-019 o_bus_en, o_wr_en, o_wr_data, o_addr, o_byte_en, o_atomic, o_operation  out  1, 1, XLEN, XLEN, 4, 1, 7  downstream request fields.
REQ-020 o_id  out  ID_W  index of the granted master.

Function
REQ-021 SHALL implement a two-state FSM: IDLE and BUSY.
REQ-022 In IDLE with any i_m_bus_en high, SHALL register grant index g and enter BUSY at the next edge; with no requests, SHALL remain in IDLE.
REQ-023 Round-robin: SHALL search from (last_grant+1) mod N_MASTERS upward with wrap-around; fixed priority: SHALL select the lowest set index.
REQ-024 In BUSY, o_bus_en SHALL be 1 and all downstream fields SHALL be master g's fields, muxed from the registered g; o_id SHALL equal g.
REQ-025 In IDLE, o_bus_en, o_wr_en, o_atomic SHALL be 0 and o_id SHALL hold its last value.
REQ-026 Latency: request first seen in cycle n -> o_bus_en high in cycle n+1.
REQ-027 o_m_ack[g] SHALL equal i_ack while in BUSY, combinationally; all other o_m_ack bits SHALL be 0; o_m_rd_data SHALL equal i_rd_data.
REQ-028 i_ack while in IDLE SHALL be ignored.
REQ-029 On i_ack in BUSY, when i_m_lock[g]=1, i_m_bus_en[g]=1 and lock_cnt<LOCK_MAX-1, SHALL stay BUSY with the same g and increment lock_cnt.
REQ-030 On i_ack in BUSY otherwise, SHALL go IDLE, clear lock_cnt and set last_grant=g; the next grant costs one idle cycle.
REQ-031 On lock expiry (lock_cnt reaching LOCK_MAX-1 at ack), SHALL force IDLE; in round-robin mode g SHALL lose priority to other requesters.
REQ-032 A master dropping i_m_bus_en[g] before its ack is a protocol violation; behaviour is undefined, but the FSM SHALL return to IDLE at the next i_ack.
REQ-033 lock_cnt SHALL be clog2(LOCK_MAX)+1 bits and SHALL saturate, never wrap.

Reset
REQ-034 While i_rst=0, SHALL asynchronously force state=IDLE, g=0, o_id=0, last_grant=N_MASTERS-1 (so master 0 wins first in round-robin), lock_cnt=0, and all o_m_ack=0.
REQ-035 Reset asserted mid-transaction SHALL abandon the transaction with no ack delivered; after release, arbitration SHALL restart from REQ-034 values.

Verification
REQ-036 N=4, RR: all four request at once, i_ack 1 cycle after each o_bus_en -> o_id sequence 0,1,2,3,0; one idle cycle between grants.
REQ-037 N=4, fixed priority: masters 1 and 3 request continuously -> o_id=1 every grant; master 3 is never acked.
REQ-038 Master 2 with i_m_lock=1 and LOCK_MAX=3, master 0 also requesting -> three back-to-back grants to 2 with o_bus_en held high, then IDLE, then o_id=0.
REQ-039 Master 1 write (addr 0x100, data 0xDEADBEEF, byte_en 0xF, atomic=1, op=0x08) -> downstream fields match exactly, o_m_ack=4'b0010 on i_ack, other acks 0.
REQ-040 i_rst pulsed low while BUSY before i_ack -> o_bus_en=0 immediately, o_id=0; after release, a request from all four masters grants master 0 first.
